// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decides taken/not-taken for conditional branches and
// jumps in EX, computes the actual next PC, raises a registered one-cycle
// redirect/flush on a mispredict, and owns the 2-bit BHT used by fetch.
module branch_resolve_unit #(
    parameter int BHT_IDX_W = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_pred_taken,
    input  logic            BrEq,
    input  logic            BrLt,
    output logic [1:0]      BrUn,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mis_count
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    typedef enum logic {S_IDLE = 1'b0, S_SHADOW = 1'b1} state_t;

    state_t state_q, state_d;

    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]     br_count_q, br_count_d;
    logic [31:0]     mis_count_q, mis_count_d;
    logic [1:0]      bht_q [BHT_N];
    logic [1:0]      bht_d [BHT_N];

    logic                 shadow, resolve, is_jump, cond_legal;
    logic                 cmp_taken, taken, mispredict, br_resolve;
    logic [XLEN-1:0]      jalr_sum, target, actual_pc;
    logic [BHT_IDX_W-1:0] ex_idx, if_idx;
    logic                 unused_pc_bits;

    assign ex_idx = ex_pc[BHT_IDX_W+1:2];
    assign if_idx = if_pc[BHT_IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:BHT_IDX_W+2], ex_pc[1:0]};

    // Comparator mode select: funct3 11x are the unsigned compares
    always_comb begin
        BrUn = 2'b00;
        if (ex_valid && ex_is_branch)
            BrUn = (ex_funct3[2:1] == 2'b11) ? 2'b01 : 2'b11;
    end

    // Resolve decision, target arithmetic and mispredict detection
    always_comb begin
        shadow     = (state_q == S_SHADOW);
        resolve    = ex_valid && !ex_stall && !shadow;
        is_jump    = ex_is_jal || ex_is_jalr;
        // funct3 010/011 are not branch encodings; they never update state
        cond_legal = ex_is_branch && !is_jump && (ex_funct3[2:1] != 2'b01);
        case (ex_funct3)
            3'b000:          cmp_taken = BrEq;
            3'b001:          cmp_taken = !BrEq;
            3'b100, 3'b110:  cmp_taken = BrLt;
            3'b101, 3'b111:  cmp_taken = !BrLt;
            default:         cmp_taken = 1'b0;
        endcase
        taken      = is_jump || (cond_legal && cmp_taken);
        jalr_sum   = ex_rs1 + ex_imm;
        target     = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
        actual_pc  = taken ? target : (ex_pc + XLEN'(4));
        // Fetch never predicts jumps, so every jump is a redirect
        mispredict = is_jump || (cond_legal && (taken != ex_pred_taken));
        br_resolve = resolve && cond_legal;
    end

    // Next-state: a redirect opens one shadow cycle; stalls hold the shadow
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (resolve && mispredict) state_d = S_SHADOW;
            S_SHADOW: if (!ex_stall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs and statistics computed from the resolve decision
    always_comb begin
        redirect_valid_d = (state_q == S_IDLE) && resolve && mispredict;
        redirect_pc_d    = redirect_valid_d ? actual_pc : redirect_pc_q;
        br_count_d       = br_count_q;
        mis_count_d      = mis_count_q;
        if (br_resolve && (br_count_q != 32'hFFFF_FFFF))
            br_count_d = br_count_q + 32'd1;
        if (redirect_valid_d && (mis_count_q != 32'hFFFF_FFFF))
            mis_count_d = mis_count_q + 32'd1;
    end

    // BHT saturating-counter update for resolved legal conditional branches
    always_comb begin
        for (int i = 0; i < BHT_N; i++) bht_d[i] = bht_q[i];
        if (br_resolve) begin
            if (taken && (bht_q[ex_idx] != 2'b11))
                bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            else if (!taken && (bht_q[ex_idx] != 2'b00))
                bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
        end
    end

    // State, redirect, counters and BHT registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            mis_count_q      <= '0;
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            br_count_q       <= br_count_d;
            mis_count_q      <= mis_count_d;
            for (int i = 0; i < BHT_N; i++) bht_q[i] <= bht_d[i];
        end
    end

    assign if_pred_taken  = bht_q[if_idx][1];
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = redirect_valid_q;
    assign br_count       = br_count_q;
    assign mis_count      = mis_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: each driven EX cycle pushes the
// expected redirect for the following cycle; it is popped and compared after
// the clock edge.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        ex_pred_taken, BrEq, BrLt;
    logic [1:0]  BrUn;
    logic [31:0] if_pc;
    logic        if_pred_taken, redirect_valid, flush;
    logic [31:0] redirect_pc, br_count, mis_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    branch_resolve_unit #(.BHT_IDX_W(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .br_count(br_count), .mis_count(mis_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one EX cycle (entered just after a rising edge), check BrUn,
    // push the expected redirect, clock, then pop and compare.
    task automatic step(input string tag,
                        input logic v, input logic st, input logic br,
                        input logic jal, input logic jalr, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic pred,
                        input logic eq, input logic lt,
                        input logic [1:0] exp_brun,
                        input logic exp_rv, input logic [31:0] exp_pc);
        exp_t e;
        ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal;
        ex_is_jalr = jalr; ex_funct3 = f3; ex_pc = pc; ex_imm = imm;
        ex_rs1 = rs1; ex_pred_taken = pred; BrEq = eq; BrLt = lt;
        #1;
        check({tag, ".brun"}, {30'd0, BrUn}, {30'd0, exp_brun});
        e.v = exp_rv; e.pc = exp_pc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, e.v});
            check({tag, ".flush"}, {31'd0, flush}, {31'd0, e.v});
            if (e.v) check({tag, ".rpc"}, redirect_pc, e.pc);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 0, 32'h0);
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    task automatic counts(input string tag, input logic [31:0] br, input logic [31:0] mis);
        check({tag, ".br_count"}, br_count, br);
        check({tag, ".mis_count"}, mis_count, mis);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_pred_taken = 0;
        BrEq = 0; BrLt = 0; if_pc = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        check("rst.rv", {31'd0, redirect_valid}, 32'd0);
        check("rst.flush", {31'd0, flush}, 32'd0);
        check("rst.rpc", redirect_pc, 32'd0);
        counts("rst", 0, 0);
        pred_at("rst.pred40", 32'h40, 0);
        rst_n = 1'b1;

        // BEQ taken, predicted not taken -> redirect to 0x120
        step("beq", 1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 0, 1, 0, 2'b11, 1, 32'h120);
        counts("beq", 1, 1);
        // Shadow cycle; invalid branch must not drive the comparator mode
        step("shadow0", 0, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 0, 1, 0, 2'b00, 0, 32'h0);

        // BLTU not taken, predicted not taken: BHT[0] 2 -> 1
        step("bltu", 1, 0, 1, 0, 0, 3'b110, 32'h200, 32'h8, 0, 0, 0, 0, 2'b01, 0, 32'h0);
        counts("bltu", 2, 1);
        pred_at("bltu.pred", 32'h200, 0);

        // BEQ taken three times, correctly predicted: 1 -> 2 -> 3 -> 3
        for (int i = 0; i < 3; i++)
            step("beq_sat", 1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 1, 1, 0, 2'b11, 0, 32'h0);
        counts("beq_sat", 5, 1);
        pred_at("beq_sat.pred", 32'h100, 1);

        // JALR clears bit 0 of the target
        step("jalr", 1, 0, 0, 0, 1, 3'b000, 32'h300, 32'h4, 32'h1003, 0, 0, 0, 2'b00, 1, 32'h1006);
        counts("jalr", 5, 2);
        // Wrong-path mispredicting branch in the shadow slot is ignored
        step("jalr_shadow", 1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 1, 0, 0, 2'b11, 0, 32'h0);
        counts("jalr_shadow", 5, 2);

        // JAL, then the shadow is held across two stalled cycles
        step("jal", 1, 0, 0, 1, 0, 3'b000, 32'h400, 32'h10, 0, 0, 0, 0, 2'b00, 1, 32'h410);
        step("stall_a", 1, 1, 1, 0, 0, 3'b001, 32'h100, 32'h20, 0, 0, 0, 0, 2'b11, 0, 32'h0);
        step("stall_b", 1, 1, 1, 0, 0, 3'b001, 32'h100, 32'h20, 0, 0, 0, 0, 2'b11, 0, 32'h0);
        step("stall_exit", 1, 0, 1, 0, 0, 3'b001, 32'h100, 32'h20, 0, 0, 0, 0, 2'b11, 0, 32'h0);
        counts("stall", 5, 3);

        // BNE wrap-around target
        step("bne_wrap", 1, 0, 1, 0, 0, 3'b001, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 2'b11, 1, 32'h10);
        counts("bne_wrap", 6, 4);
        idle("wrap_shadow");
        pred_at("wrap.pred", 32'hFFFF_FFF0, 1);

        // Illegal funct3 010: not taken, no count, no redirect
        step("illegal", 1, 0, 1, 0, 0, 3'b010, 32'h100, 32'h20, 0, 1, 1, 1, 2'b11, 0, 32'h0);
        counts("illegal", 6, 4);

        // BGE not taken but predicted taken -> fall-through redirect
        step("bge", 1, 0, 1, 0, 0, 3'b101, 32'h500, 32'h40, 0, 1, 0, 1, 2'b11, 1, 32'h504);
        counts("bge", 7, 5);
        idle("bge_shadow");

        // A stalled jump in IDLE does not resolve
        step("jal_stall", 1, 1, 0, 1, 0, 3'b000, 32'h700, 32'h10, 0, 0, 0, 0, 2'b00, 0, 32'h0);
        counts("jal_stall", 7, 5);

        // JAL into SHADOW, then asynchronous reset mid-shadow
        step("jal_rst", 1, 0, 0, 1, 0, 3'b000, 32'h600, 32'h8, 0, 0, 0, 0, 2'b00, 1, 32'h608);
        rst_n = 1'b0;
        #1;
        check("arst.rv", {31'd0, redirect_valid}, 32'd0);
        check("arst.flush", {31'd0, flush}, 32'd0);
        check("arst.rpc", redirect_pc, 32'd0);
        counts("arst", 0, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) pred_at("arst.bht", 32'(i) << 2, 0);

        // After reset the FSM is IDLE and BHT[0] is weakly not-taken (1 -> 2)
        step("post_rst", 1, 0, 1, 0, 0, 3'b000, 32'h100, 32'h20, 0, 0, 1, 0, 2'b11, 1, 32'h120);
        counts("post_rst", 1, 1);
        pred_at("post_rst.pred", 32'h100, 1);
        idle("post_shadow");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
